// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe controller and its hole generator.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    typedef logic [11:0] coord_t;
    typedef logic [9:0]  score_t;

    localparam score_t SCORE_MAX = 10'd1023;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fixed hole-centre sequence used when the LFSR source is not built in.
    localparam coord_t HOLE_TABLE [16] = '{
        12'd220, 12'd130, 12'd310, 12'd290,
        12'd160, 12'd340, 12'd140, 12'd330,
        12'd275, 12'd225, 12'd150, 12'd200,
        12'd190, 12'd340, 12'd280, 12'd170
    };

    // Clamp a coordinate into [lo, hi].
    function automatic coord_t clamp_coord(coord_t v, coord_t lo, coord_t hi);
        coord_t r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hole_gen.sv
// hole_gen: produces the next hole-centre Y and advances one step per value taken.
// Build option PIPE_CTRL_LFSR_EN selects an 8-bit LFSR source folded into
// [HOLE_MIN, HOLE_MAX]; otherwise a 16-entry table is walked with a wrapping index.
module hole_gen
    import pipe_pkg::*;
#(
    parameter int HOLE_MIN = 130,
    parameter int HOLE_MAX = 350
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_step,
    output logic [11:0] o_y
);

`ifdef PIPE_CTRL_LFSR_EN
    localparam coord_t RANGE      = coord_t'(HOLE_MAX - HOLE_MIN);
    localparam coord_t RANGE_WRAP = coord_t'(HOLE_MAX - HOLE_MIN + 1);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    coord_t     v_ext;

    // Taps for x^8+x^6+x^5+x^4+1; shift only when a value is consumed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (i_step) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // LFSR state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Fold the 0..255 value back into the hole window (range is 127..255 wide).
    always_comb begin
        v_ext = {4'd0, lfsr_q};
        if (v_ext <= RANGE) begin
            o_y = coord_t'(HOLE_MIN) + v_ext;
        end else begin
            o_y = coord_t'(HOLE_MIN) + v_ext - RANGE_WRAP;
        end
    end
`else
    logic [3:0] idx_q;
    logic [3:0] idx_d;

    // Index wraps naturally at 16 entries.
    always_comb begin
        idx_d = idx_q;
        if (i_step) begin
            idx_d = idx_q + 4'd1;
        end
    end

    // Table index register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q <= 4'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Table lookup clamped to the configured window.
    always_comb begin
        o_y = clamp_coord(HOLE_TABLE[idx_q], coord_t'(HOLE_MIN), coord_t'(HOLE_MAX));
    end
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: game FSM, pipe release scheduler, hole-load arbiter and scoring.
// Hole source is chosen at build time by PIPE_CTRL_LFSR_EN (see hole_gen).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int N_PIPES    = 3,
    parameter int SPAWN_GAP  = 32,
    parameter int SPEED_INIT = 7,
    parameter int SPEED_MAX  = 15,
    parameter int SPEED_STEP = 5,
    parameter int HOLE_MIN   = 130,
    parameter int HOLE_MAX   = 350,
    parameter int DEAD_TICKS = 60
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_physics_stb,
    input  logic               i_flap,
    input  logic               i_collide,
    input  logic [N_PIPES-1:0] i_point,
    output logic [N_PIPES-1:0] o_pipe_run,
    output logic [N_PIPES-1:0] o_pipe_rst,
    output logic [N_PIPES-1:0] o_hole_load,
    output logic [11:0]        o_hole_y,
    output logic [5:0]         o_speed,
    output logic [9:0]         o_score,
    output logic [9:0]         o_hiscore,
    output logic [1:0]         o_state
);

    localparam int GAP_W  = $clog2(SPAWN_GAP + 1);
    localparam int IDX_W  = $clog2(N_PIPES + 1);
    localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
    localparam int STEP_W = $clog2(SPEED_STEP + 1);

    state_t             state_q,     state_d;
    logic [N_PIPES-1:0] pipe_run_q,  pipe_run_d;
    logic [N_PIPES-1:0] pipe_rst_q,  pipe_rst_d;
    logic [N_PIPES-1:0] hole_load_q, hole_load_d;
    coord_t             hole_y_q,    hole_y_d;
    logic [5:0]         speed_q,     speed_d;
    score_t             score_q,     score_d;
    score_t             hiscore_q,   hiscore_d;
    logic [IDX_W-1:0]   rel_idx_q,   rel_idx_d;
    logic [GAP_W-1:0]   gap_q,       gap_d;
    logic [DEAD_W-1:0]  dead_q,      dead_d;
    logic [STEP_W-1:0]  step_cnt_q,  step_cnt_d;
    logic [N_PIPES-1:0] pend_load_q, pend_load_d;
    logic [N_PIPES-1:0] pend_pt_q,   pend_pt_d;

    logic [N_PIPES-1:0] new_rel;
    logic [N_PIPES-1:0] req;
    logic [N_PIPES-1:0] pt_req;
    logic [N_PIPES-1:0] sel;
    logic               hole_step;
    coord_t             gen_y;

    hole_gen #(
        .HOLE_MIN (HOLE_MIN),
        .HOLE_MAX (HOLE_MAX)
    ) u_hole_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_step  (hole_step),
        .o_y     (gen_y)
    );

    // Next-state logic: FSM, release schedule, lowest-index-first hole loads, scoring.
    always_comb begin
        state_d     = state_q;
        pipe_run_d  = pipe_run_q;
        pipe_rst_d  = '0;
        hole_load_d = '0;
        hole_y_d    = hole_y_q;
        speed_d     = speed_q;
        score_d     = score_q;
        hiscore_d   = hiscore_q;
        rel_idx_d   = rel_idx_q;
        gap_d       = gap_q;
        dead_d      = dead_q;
        step_cnt_d  = step_cnt_q;
        pend_load_d = pend_load_q;
        pend_pt_d   = pend_pt_q;
        new_rel     = '0;
        req         = '0;
        pt_req      = '0;
        sel         = '0;
        hole_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_flap) begin
                    state_d     = ST_RUN;
                    pipe_rst_d  = '1;
                    pipe_run_d  = '0;
                    score_d     = '0;
                    speed_d     = 6'(SPEED_INIT);
                    rel_idx_d   = '0;
                    gap_d       = '0;
                    step_cnt_d  = '0;
                    pend_load_d = '0;
                    pend_pt_d   = '0;
                end
            end

            ST_RUN: begin
                if (i_collide) begin
                    // Collision wins over any point arriving in the same cycle.
                    state_d     = ST_DEAD;
                    pipe_run_d  = '0;
                    hiscore_d   = (score_q > hiscore_q) ? score_q : hiscore_q;
                    dead_d      = '0;
                    pend_load_d = '0;
                    pend_pt_d   = '0;
                end else begin
                    if (i_physics_stb) begin
                        if (rel_idx_q < IDX_W'(N_PIPES) && gap_q == '0) begin
                            new_rel    = N_PIPES'(1) << rel_idx_q;
                            pipe_run_d = pipe_run_q | new_rel;
                            rel_idx_d  = rel_idx_q + 1'b1;
                            gap_d      = GAP_W'(SPAWN_GAP - 1);
                        end else if (gap_q != '0) begin
                            gap_d = gap_q - 1'b1;
                        end
                    end

                    req    = pend_load_q | i_point | new_rel;
                    pt_req = pend_pt_q | i_point;
                    sel    = req & (~req + 1'b1);

                    if (req != '0) begin
                        hole_load_d = sel;
                        hole_y_d    = gen_y;
                        hole_step   = 1'b1;
                        if ((sel & pt_req) != '0) begin
                            if (score_q != SCORE_MAX) begin
                                score_d = score_q + 1'b1;
                            end
                            if (step_cnt_q == STEP_W'(SPEED_STEP - 1)) begin
                                step_cnt_d = '0;
                                if (speed_q < 6'(SPEED_MAX)) begin
                                    speed_d = speed_q + 1'b1;
                                end
                            end else begin
                                step_cnt_d = step_cnt_q + 1'b1;
                            end
                        end
                    end

                    pend_load_d = req & ~sel;
                    pend_pt_d   = pt_req & ~sel;
                end
            end

            ST_DEAD: begin
                if (i_physics_stb) begin
                    if (dead_q == DEAD_W'(DEAD_TICKS - 1)) begin
                        state_d = ST_OVER;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (i_flap) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            pipe_run_q  <= '0;
            pipe_rst_q  <= '0;
            hole_load_q <= '0;
            hole_y_q    <= '0;
            speed_q     <= 6'(SPEED_INIT);
            score_q     <= '0;
            hiscore_q   <= '0;
            rel_idx_q   <= '0;
            gap_q       <= '0;
            dead_q      <= '0;
            step_cnt_q  <= '0;
            pend_load_q <= '0;
            pend_pt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pipe_run_q  <= pipe_run_d;
            pipe_rst_q  <= pipe_rst_d;
            hole_load_q <= hole_load_d;
            hole_y_q    <= hole_y_d;
            speed_q     <= speed_d;
            score_q     <= score_d;
            hiscore_q   <= hiscore_d;
            rel_idx_q   <= rel_idx_d;
            gap_q       <= gap_d;
            dead_q      <= dead_d;
            step_cnt_q  <= step_cnt_d;
            pend_load_q <= pend_load_d;
            pend_pt_q   <= pend_pt_d;
        end
    end

    assign o_state     = state_q;
    assign o_pipe_run  = pipe_run_q;
    assign o_pipe_rst  = pipe_rst_q;
    assign o_hole_load = hole_load_q;
    assign o_hole_y    = hole_y_q;
    assign o_speed     = speed_q;
    assign o_score     = score_q;
    assign o_hiscore   = hiscore_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter N_PIPES, default 3, number of pipe instances sequenced.
REQ-002 Parameter SPAWN_GAP, default 32, physics ticks between successive pipe releases.
REQ-003 Parameter SPEED_INIT, default 7; SPEED_MAX, default 15; SPEED_STEP, default 5 points per speed increment.
REQ-004 Parameter HOLE_MIN, default 130; HOLE_MAX, default 350; hole-centre Y bounds, HOLE_MAX-HOLE_MIN SHALL be 127..255.
REQ-005 Parameter DEAD_TICKS, default 60, physics ticks spent in DEAD before OVER.
REQ-006 i_clk  in  1  base clock; all state on rising edge.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_physics_stb  in  1  one-cycle physics tick strobe.
REQ-009 i_flap  in  1  one-cycle debounced button pulse.
REQ-010 i_collide  in  1  level, bird overlaps pipe or floor.
REQ-011 i_point  in  N_PIPES  per-pipe one-cycle wrap pulse.
REQ-012 o_pipe_run  out  N_PIPES  per-pipe motion enable.
REQ-013 o_pipe_rst  out  N_PIPES  per-pipe one-cycle return-to-start pulse.
REQ-014 o_hole_load  out  N_PIPES  one-hot strobe; pipe k latches o_hole_y.
REQ-015 o_hole_y  out  12  hole centre, valid when any o_hole_load bit set.
REQ-016 o_speed  out  6  scroll speed, pixels per physics tick.
REQ-017 o_score  out  10; o_hiscore  out  10; o_state  out  2 (IDLE=0, RUN=1, DEAD=2, OVER=3).

Function
REQ-018 FSM IDLE->RUN on i_flap; RUN->DEAD on i_collide; DEAD->OVER after DEAD_TICKS physics ticks; OVER->IDLE on i_flap.
REQ-019 Entering RUN: o_pipe_rst all ones for one cycle, o_score cleared, o_speed=SPEED_INIT, release index=0, gap counter=0.
REQ-020 In RUN, pipe k released (o_pipe_run[k] set, o_hole_load[k] pulsed) at physics tick k*SPAWN_GAP after RUN entry; pipe 0 on the first tick.
REQ-021 In RUN, i_point[k] SHALL cause o_hole_load[k] plus new o_hole_y exactly one cycle later; score+1 in same cycle as load.
REQ-022 Multiple i_point bits in one cycle: loads serviced lowest index first, one per cycle; score adds each; pending bits held.
REQ-023 Score saturates at 1023; every SPEED_STEP-th point increments o_speed, saturating at SPEED_MAX.
REQ-024 i_collide and i_point same cycle: collision wins, point discarded, no score change.
REQ-025 Entering DEAD: o_pipe_run cleared same cycle; o_hiscore updated to max(o_hiscore, o_score).
REQ-026 i_flap ignored in RUN and DEAD; i_collide ignored outside RUN.
REQ-027 Hole generator advances one step per generated value; output always within [HOLE_MIN, HOLE_MAX].

Reset
REQ-028 i_rst_n low: state IDLE, all outputs zero except o_speed=SPEED_INIT, o_hiscore=0, generator at seed; takes effect without clock.
REQ-029 Reset deassertion mid-RUN returns to IDLE; no o_hole_load or o_pipe_rst pulse in the first cycle after deassertion.

Configuration
REQ-030 Macro PIPE_CTRL_LFSR_EN defined: hole from 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed 0xA5; v=LFSR value; o_hole_y=HOLE_MIN+v if v<=HOLE_MAX-HOLE_MIN else HOLE_MIN+v-(HOLE_MAX-HOLE_MIN+1).
REQ-031 Macro undefined: hole from fixed 16-entry table {220,130,310,290,160,340,140,330,275,225,150,200,190,340,280,170} via 4-bit wrapping index, each entry clamped to [HOLE_MIN, HOLE_MAX].

Structure
REQ-032 Shared package pipe_pkg SHALL hold state enum, 12-bit coordinate type, 10-bit score type, hole table constant.
REQ-033 Hole source SHALL be sub-module hole_gen (i_clk, i_rst_n, step, 12-bit y); FSM, release scheduler, score in pipe_ctrl.

Verification
REQ-034 Reset, flap, 100 physics ticks -> o_pipe_run 001, 011, 111 at ticks 1, 33, 65; three o_hole_load pulses.
REQ-035 RUN, i_point=010 -> next cycle o_hole_load=010, o_score=1; after 5th point o_speed=8.
REQ-036 i_point=101 one cycle -> o_hole_load 001 then 100 on consecutive cycles, o_score+2.
REQ-037 i_collide with i_point=001 at score 4 -> o_state=DEAD, o_pipe_run=0, score 4, hiscore 4; 60 ticks -> OVER; flap -> IDLE.
REQ-038 1000 holes in each configuration -> every o_hole_y within 130..350; without macro, sequence starts 220,130,310.
REQ-039 i_rst_n low mid-RUN without clock -> outputs at reset values immediately.
